sobel_grad_filter: RTL and testbench



---
 rtl/sobel_grad_filter.sv | 161 ++++++++++++++++
 tb/tb_sobel_grad_filter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_grad_filter.sv
// -----------------------------------------------------------------------------
// sobel_grad_filter
//   3x3 Sobel gradient engine. Accepts one vertical 3-pixel column per transfer,
//   keeps a sliding window of the last three columns and produces one of
//   |Gx|, |Gy|, |Gx|+|Gy| or a thresholded binary edge per full window.
//   Three-stage pipeline (window -> weighted sums -> output) with valid/ack
//   backpressure; all stages advance together.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_pixel_1/2/3         top/middle/bottom pixel of the incoming column
//   i_pixel_sol           start of line, qualifies the accompanying column
//   i_pixel_valid         column valid
//   o_pixel_ack           ready to accept a column (combinational)
//   i_mode, i_thresh      result select and threshold, sampled per transfer
//   o_pixel               result, zero-extended to OUT_W
//   o_pixel_valid         result valid, held until consumed
//   i_pixel_ack           downstream accept
// -----------------------------------------------------------------------------
module sobel_grad_filter #(
  parameter int PIX_W = 8,
  parameter int OUT_W = PIX_W + 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PIX_W-1:0] i_pixel_1,
  input  logic [PIX_W-1:0] i_pixel_2,
  input  logic [PIX_W-1:0] i_pixel_3,
  input  logic             i_pixel_sol,
  input  logic             i_pixel_valid,
  output logic             o_pixel_ack,
  input  logic [1:0]       i_mode,
  input  logic [OUT_W-1:0] i_thresh,
  output logic [OUT_W-1:0] o_pixel,
  output logic             o_pixel_valid,
  input  logic             i_pixel_ack
);

  localparam int SW = PIX_W + 2;

  // Window columns, index 0 is the oldest column, index 2 the newest.
  logic [PIX_W-1:0] win_top [3];
  logic [PIX_W-1:0] win_mid [3];
  logic [PIX_W-1:0] win_bot [3];
  logic [1:0]       fill_cnt;
  logic             v1;
  logic [1:0]       mode1;
  logic [OUT_W-1:0] thresh1;

  logic [SW-1:0]    sx2, sx0, sy1, sy3;
  logic             v2;
  logic [1:0]       mode2;
  logic [OUT_W-1:0] thresh2;

  logic en;
  logic xfer;
  logic full;

  // The whole pipeline moves only when the output slot is free or being drained.
  assign en          = !o_pixel_valid | i_pixel_ack;
  assign o_pixel_ack = en;
  assign xfer        = i_pixel_valid & en;
  // A token is issued only when two in-line columns precede this one.
  assign full        = xfer & (fill_cnt == 2'd2) & !i_pixel_sol;

  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Stage 1: window shift, fill tracking and token capture of mode/threshold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        win_top[i] <= '0;
        win_mid[i] <= '0;
        win_bot[i] <= '0;
      end
      fill_cnt <= 2'd0;
      v1       <= 1'b0;
      mode1    <= 2'd0;
      thresh1  <= '0;
    end else if (en) begin
      v1 <= full;
      if (xfer) begin
        win_top[0] <= win_top[1];
        win_mid[0] <= win_mid[1];
        win_bot[0] <= win_bot[1];
        win_top[1] <= win_top[2];
        win_mid[1] <= win_mid[2];
        win_bot[1] <= win_bot[2];
        win_top[2] <= i_pixel_1;
        win_mid[2] <= i_pixel_2;
        win_bot[2] <= i_pixel_3;
        // sol restarts the line: the new column counts as the first one.
        if (i_pixel_sol) begin
          fill_cnt <= 2'd1;
        end else if (fill_cnt != 2'd2) begin
          fill_cnt <= fill_cnt + 2'd1;
        end
      end
      if (full) begin
        mode1   <= i_mode;
        thresh1 <= i_thresh;
      end
    end
  end

  // Stage 2: the four weighted column/row sums of the Sobel kernels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sx2     <= '0;
      sx0     <= '0;
      sy1     <= '0;
      sy3     <= '0;
      v2      <= 1'b0;
      mode2   <= 2'd0;
      thresh2 <= '0;
    end else if (en) begin
      sx2     <= wsum(win_top[2], win_mid[2], win_bot[2]);
      sx0     <= wsum(win_top[0], win_mid[0], win_bot[0]);
      sy1     <= wsum(win_top[0], win_top[1], win_top[2]);
      sy3     <= wsum(win_bot[0], win_bot[1], win_bot[2]);
      v2      <= v1;
      mode2   <= mode1;
      thresh2 <= thresh1;
    end
  end

  logic [SW-1:0]    ax, ay;
  logic [OUT_W-1:0] ax_w, ay_w, sum_w, result;

  // Absolute differences as larger minus smaller, so everything stays unsigned.
  always_comb begin
    ax     = (sx2 >= sx0) ? (sx2 - sx0) : (sx0 - sx2);
    ay     = (sy1 >= sy3) ? (sy1 - sy3) : (sy3 - sy1);
    ax_w   = {{(OUT_W-SW){1'b0}}, ax};
    ay_w   = {{(OUT_W-SW){1'b0}}, ay};
    sum_w  = ax_w + ay_w;
    result = '0;
    case (mode2)
      2'd0:    result = ax_w;
      2'd1:    result = ay_w;
      2'd2:    result = sum_w;
      default: result = (sum_w >= thresh2) ? '1 : '0;
    endcase
  end

  // Stage 3: output register; bubbles leave a zero result behind them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else if (en) begin
      o_pixel       <= v2 ? result : '0;
      o_pixel_valid <= v2;
    end
  end

endmodule

// File: tb/tb_sobel_grad_filter.sv
// -----------------------------------------------------------------------------
// tb_sobel_grad_filter
//   Directed self-checking bench for sobel_grad_filter (PIX_W=8, OUT_W=11).
//   Inputs change 1ns after each rising edge; outputs are sampled a further
//   1ns later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_sobel_grad_filter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [7:0]  i_pixel_1 = '0;
  logic [7:0]  i_pixel_2 = '0;
  logic [7:0]  i_pixel_3 = '0;
  logic        i_pixel_sol = 1'b0;
  logic        i_pixel_valid = 1'b0;
  logic        o_pixel_ack;
  logic [1:0]  i_mode = '0;
  logic [10:0] i_thresh = '0;
  logic [10:0] o_pixel;
  logic        o_pixel_valid;
  logic        i_pixel_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  // Stream tables used by runStream.
  logic [7:0]  col_val  [8];
  logic        col_sol  [8];
  logic [1:0]  col_mode [8];
  logic [10:0] col_thr  [8];
  int          exp_out  [8];
  int          n_exp;

  sobel_grad_filter #(.PIX_W(8), .OUT_W(11)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pixel_1     (i_pixel_1),
    .i_pixel_2     (i_pixel_2),
    .i_pixel_3     (i_pixel_3),
    .i_pixel_sol   (i_pixel_sol),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_ack   (o_pixel_ack),
    .i_mode        (i_mode),
    .i_thresh      (i_thresh),
    .o_pixel       (o_pixel),
    .o_pixel_valid (o_pixel_valid),
    .i_pixel_ack   (i_pixel_ack)
  );

  always #5 i_clk = ~i_clk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one column for exactly one edge; called at edge+1 with ack high.
  task automatic applyStimulus(input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                               input logic sol, input logic [1:0] mode, input logic [10:0] thr);
    i_pixel_1     = p1;
    i_pixel_2     = p2;
    i_pixel_3     = p3;
    i_pixel_sol   = sol;
    i_mode        = mode;
    i_thresh      = thr;
    i_pixel_valid = 1'b1;
    tick();
    i_pixel_valid = 1'b0;
    i_pixel_sol   = 1'b0;
  endtask

  // Three-column window starting a new line; result expected two edges later.
  task automatic sendWindow(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                            input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                            input logic [1:0] mode, input logic [10:0] thr,
                            input int exp, input string tag);
    applyStimulus(a1, a2, a3, 1'b1, mode, thr);
    applyStimulus(b1, b2, b3, 1'b0, mode, thr);
    applyStimulus(c1, c2, c3, 1'b0, mode, thr);
    tick();
    tick();
    checkOutput({tag, "_valid"}, o_pixel_valid, 1);
    checkOutput({tag, "_data"}, o_pixel, exp);
    tick();
    checkOutput({tag, "_drained"}, o_pixel_valid, 0);
  endtask

  // Streams the 8 table columns, holding downstream ack low over [stall_from, stall_to].
  task automatic runStream(input int stall_from, input int stall_to, input string tag);
    int col_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    logic drive_ack;
    while (out_idx < n_exp && cyc < 60) begin
      drive_ack   = !(cyc >= stall_from && cyc <= stall_to);
      i_pixel_ack = drive_ack;
      if (col_idx < 8) begin
        i_pixel_1     = col_val[col_idx];
        i_pixel_2     = col_val[col_idx];
        i_pixel_3     = col_val[col_idx];
        i_pixel_sol   = col_sol[col_idx];
        i_mode        = col_mode[col_idx];
        i_thresh      = col_thr[col_idx];
        i_pixel_valid = 1'b1;
      end else begin
        i_pixel_valid = 1'b0;
        i_pixel_sol   = 1'b0;
      end
      #1;
      if (!drive_ack) begin
        checkOutput({tag, "_stall_valid"}, o_pixel_valid, 1);
        checkOutput({tag, "_stall_ack"}, o_pixel_ack, 0);
        checkOutput({tag, "_stall_hold"}, o_pixel, exp_out[out_idx]);
      end else begin
        checkOutput({tag, "_ack"}, o_pixel_ack, 1);
        if (o_pixel_valid) begin
          checkOutput({tag, "_data"}, o_pixel, exp_out[out_idx]);
          out_idx++;
        end
      end
      if (i_pixel_valid && drive_ack) col_idx++;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_pixel_valid = 1'b0;
    i_pixel_sol   = 1'b0;
    i_pixel_ack   = 1'b1;
    checkOutput({tag, "_count"}, out_idx, n_exp);
    checkOutput({tag, "_cols"}, col_idx, 8);
    checkOutput({tag, "_nodup0"}, o_pixel_valid, 0);
    tick();
    checkOutput({tag, "_nodup1"}, o_pixel_valid, 0);
  endtask

  initial begin
    // Reset state; downstream ack low so o_pixel_ack=1 comes from the empty output.
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", o_pixel_valid, 0);
    checkOutput("rst_data", o_pixel, 0);
    checkOutput("rst_ack", o_pixel_ack, 1);
    tick();
    i_rst_n     = 1'b1;
    i_pixel_ack = 1'b1;

    // Basic |Gx| with latency: 4*(50-10)=160, valid after edge E+2 only.
    applyStimulus(8'd10, 8'd10, 8'd10, 1'b1, 2'd0, 11'd0);
    applyStimulus(8'd20, 8'd20, 8'd20, 1'b0, 2'd0, 11'd0);
    applyStimulus(8'd50, 8'd50, 8'd50, 1'b0, 2'd0, 11'd0);
    checkOutput("lat_e0", o_pixel_valid, 0);
    tick();
    checkOutput("lat_e1", o_pixel_valid, 0);
    tick();
    checkOutput("lat_e2_valid", o_pixel_valid, 1);
    checkOutput("lat_e2_data", o_pixel, 160);
    tick();
    checkOutput("lat_single", o_pixel_valid, 0);

    // Top row bright: Gy = 1020, Gx = 0.
    sendWindow(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 2'd1, 11'd0, 1020, "gy");
    sendWindow(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 2'd2, 11'd0, 1020, "gsum");
    sendWindow(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 2'd0, 11'd0, 0, "gx0");

    // Corner window: |Gx|=1020, |Gy|=510, sum 1530.
    sendWindow(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 2'd0, 11'd0, 1020, "c_gx");
    sendWindow(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 2'd1, 11'd0, 510, "c_gy");
    sendWindow(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 2'd3, 11'd1000, 2047, "th1000");
    sendWindow(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 2'd3, 11'd1600, 0, "th1600");
    sendWindow(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 2'd3, 11'd1530, 2047, "th1530");
    sendWindow(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 2'd3, 11'd1531, 0, "th1531");

    // Stream with a 4-cycle downstream stall; last column switches to mode 3.
    col_val  = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd95, 8'd20, 8'd30};
    col_sol  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    col_mode = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
    col_thr  = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd250};
    exp_out  = '{120, 200, 280, 140, 320, 2047, 0, 0};
    n_exp    = 6;
    runStream(6, 9, "stall");

    // sol on column 5 restarts the window: no outputs for columns 5 and 6.
    col_val  = '{8'd5, 8'd15, 8'd40, 8'd80, 8'd7, 8'd9, 8'd50, 8'd12};
    col_sol  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    col_mode = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    col_thr  = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
    exp_out  = '{140, 260, 172, 12, 0, 0, 0, 0};
    n_exp    = 4;
    runStream(-1, -2, "sol");

    // Reset with tokens in flight: C's result (400) visible, D and E behind it.
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, 2'd0, 11'd0);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 2'd0, 11'd0);
    applyStimulus(8'd100, 8'd100, 8'd100, 1'b0, 2'd0, 11'd0);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 2'd0, 11'd0);
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 2'd0, 11'd0);
    checkOutput("pre_rst_valid", o_pixel_valid, 1);
    checkOutput("pre_rst_data", o_pixel, 400);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", o_pixel_valid, 0);
    checkOutput("mid_rst_data", o_pixel, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_rst_idle", o_pixel_valid, 0);
    end
    // Fill counter restarted at 0: three columns without sol make one window.
    applyStimulus(8'd10, 8'd10, 8'd10, 1'b0, 2'd0, 11'd0);
    applyStimulus(8'd20, 8'd20, 8'd20, 1'b0, 2'd0, 11'd0);
    applyStimulus(8'd40, 8'd40, 8'd40, 1'b0, 2'd0, 11'd0);
    checkOutput("post_rst_e0", o_pixel_valid, 0);
    tick();
    checkOutput("post_rst_e1", o_pixel_valid, 0);
    tick();
    checkOutput("post_rst_valid", o_pixel_valid, 1);
    checkOutput("post_rst_data", o_pixel, 120);
    tick();
    checkOutput("post_rst_drained", o_pixel_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
